gray_counter: RTL and testbench

//   Registered WIDTH-bit binary counter that produces the binary count and its

---
 rtl/gray_counter.sv | 74 +++++++
 tb/tb_gray_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Registered binary counter with an aligned Gray-code output.
// Features: synchronous load (priority over enable), enable hold,
// terminal-count flag and a sticky single-bit-change self-check.
// Optional macro GRAY_COUNTER_DOWN_EN adds a dir input for down counting.
module gray_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef GRAY_COUNTER_DOWN_EN
  input  logic             dir,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] bin_load,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             err_step
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             count_down;
  logic [WIDTH-1:0] bin_step;
  logic [WIDTH-1:0] gray_step;
  logic [WIDTH-1:0] gray_load;
  logic [WIDTH-1:0] gray_diff;
  logic             step_ok;

`ifdef GRAY_COUNTER_DOWN_EN
  assign count_down = dir;
`else
  assign count_down = 1'b0;
`endif

  // Next count value and its Gray code; the step check compares against the
  // current registered Gray value, so it must differ in exactly one bit.
  always_comb begin
    bin_step  = count_down ? (bin_out - ONE) : (bin_out + ONE);
    gray_step = bin_step ^ (bin_step >> 1);
    gray_load = bin_load ^ (bin_load >> 1);
    gray_diff = gray_step ^ gray_out;
    step_ok   = (gray_diff != '0) && ((gray_diff & (gray_diff - ONE)) == '0);
  end

  // Count, load and sticky error registers; both outputs update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      err_step <= 1'b0;
    end else if (load) begin
      bin_out  <= bin_load;
      gray_out <= gray_load;
    end else if (en) begin
      bin_out  <= bin_step;
      gray_out <= gray_step;
      if (!step_ok) begin
        err_step <= 1'b1;
      end
    end
  end

  // Terminal count decoded from the registered count, held low in reset.
  always_comb begin
    tc = 1'b0;
    if (!rst) begin
      tc = count_down ? (bin_out == '0) : (bin_out == ALL_ONES);
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        rst4 = 1'b1, en4 = 1'b0, load4 = 1'b0, dir4 = 1'b0;
  logic [3:0]  bin_load4 = '0;
  logic [3:0]  bin4, gray4;
  logic        tc4, err4;

  logic        rst32 = 1'b1, en32 = 1'b0, load32 = 1'b0, dir32 = 1'b0;
  logic [31:0] bin_load32 = '0;
  logic [31:0] bin32, gray32;
  logic        tc32, err32;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .en(en4),
`ifdef GRAY_COUNTER_DOWN_EN
    .dir(dir4),
`endif
    .load(load4), .bin_load(bin_load4),
    .bin_out(bin4), .gray_out(gray4), .tc(tc4), .err_step(err4)
  );

  gray_counter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst32), .en(en32),
`ifdef GRAY_COUNTER_DOWN_EN
    .dir(dir32),
`endif
    .load(load32), .bin_load(bin_load32),
    .bin_out(bin32), .gray_out(gray32), .tc(tc32), .err_step(err32)
  );

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; en4 = 1'b1; load4 = 1'b1; bin_load4 = 4'hF;
    repeat (3) tick();
    checks++;
    if (bin4 !== 4'h0 || gray4 !== 4'h0 || tc4 !== 1'b0 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL reset: bin=%h gray=%b tc=%b err=%b, want 0 0000 0 0", bin4, gray4, tc4, err4);
    end
  endtask

  task automatic test_count();
    logic [3:0] exp_gray [6];
    exp_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    rst4 = 1'b0; load4 = 1'b0; en4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (gray4 !== exp_gray[i] || bin4 !== 4'(i)) begin
        errors++;
        $display("FAIL count step %0d: bin=%h gray=%b, want bin=%h gray=%b", i, bin4, gray4, 4'(i), exp_gray[i]);
      end
    end
  endtask

  task automatic test_wrap();
    load4 = 1'b1; bin_load4 = 4'hE; en4 = 1'b0;
    tick();
    checks++;
    if (bin4 !== 4'hE || gray4 !== 4'b1001 || tc4 !== 1'b0) begin
      errors++;
      $display("FAIL wrap load E: bin=%h gray=%b tc=%b, want E 1001 0", bin4, gray4, tc4);
    end
    load4 = 1'b0; en4 = 1'b1;
    tick();
    checks++;
    if (bin4 !== 4'hF || gray4 !== 4'b1000 || tc4 !== 1'b1) begin
      errors++;
      $display("FAIL wrap at F: bin=%h gray=%b tc=%b, want F 1000 1", bin4, gray4, tc4);
    end
    tick();
    checks++;
    if (bin4 !== 4'h0 || gray4 !== 4'b0000 || tc4 !== 1'b0 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL wrap to 0: bin=%h gray=%b tc=%b err=%b, want 0 0000 0 0", bin4, gray4, tc4, err4);
    end
  endtask

  task automatic test_load_priority();
    load4 = 1'b1; en4 = 1'b1; bin_load4 = 4'h5;
    tick();
    checks++;
    if (bin4 !== 4'h5 || gray4 !== 4'b0111) begin
      errors++;
      $display("FAIL load priority: bin=%h gray=%b, want 5 0111", bin4, gray4);
    end
    load4 = 1'b0; en4 = 1'b0; bin_load4 = 4'hA;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bin4 !== 4'h5 || gray4 !== 4'b0111 || tc4 !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: bin=%h gray=%b tc=%b, want 5 0111 0", i, bin4, gray4, tc4);
      end
    end
  endtask

  task automatic test_mid_reset();
    load4 = 1'b1; bin_load4 = 4'h7; en4 = 1'b0;
    tick();
    load4 = 1'b0; en4 = 1'b1;
    repeat (2) tick();
    checks++;
    if (bin4 !== 4'h9 || gray4 !== 4'b1101) begin
      errors++;
      $display("FAIL mid reset pre-count: bin=%h gray=%b, want 9 1101", bin4, gray4);
    end
    rst4 = 1'b1;
    tick();
    checks++;
    if (bin4 !== 4'h0 || gray4 !== 4'h0) begin
      errors++;
      $display("FAIL mid reset: bin=%h gray=%b, want 0 0000", bin4, gray4);
    end
    rst4 = 1'b0;
    tick();
    checks++;
    if (bin4 !== 4'h1 || gray4 !== 4'b0001 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL resume after reset: bin=%h gray=%b err=%b, want 1 0001 0", bin4, gray4, err4);
    end
    en4 = 1'b0;
  endtask

  task automatic test_random32();
    logic [31:0] model;
    logic        rnd_load, rnd_en, rnd_dir;
    logic [31:0] rnd_val;
    int          bad;
    rst32 = 1'b1; en32 = 1'b0; load32 = 1'b0; dir32 = 1'b0;
    tick();
    rst32 = 1'b0;
    load32 = 1'b1; bin_load32 = 32'hFFFF_FFFF;
    tick();
    load32 = 1'b0; en32 = 1'b1;
    checks++;
    if (bin32 !== 32'hFFFF_FFFF || tc32 !== 1'b1 || gray32 !== 32'h8000_0000) begin
      errors++;
      $display("FAIL w32 all ones: bin=%h gray=%h tc=%b, want ffffffff 80000000 1", bin32, gray32, tc32);
    end
    tick();
    checks++;
    if (bin32 !== 32'h0 || gray32 !== 32'h0 || tc32 !== 1'b0) begin
      errors++;
      $display("FAIL w32 wrap: bin=%h gray=%h tc=%b, want 0 0 0", bin32, gray32, tc32);
    end
    model = 32'h0;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      rnd_load = ($urandom_range(0, 7) == 0);
      rnd_en   = ($urandom_range(0, 3) != 0);
      rnd_val  = $urandom;
`ifdef GRAY_COUNTER_DOWN_EN
      rnd_dir  = $urandom_range(0, 1) == 1;
`else
      rnd_dir  = 1'b0;
`endif
      load32 = rnd_load; en32 = rnd_en; bin_load32 = rnd_val; dir32 = rnd_dir;
      if (rnd_load)      model = rnd_val;
      else if (rnd_en)   model = rnd_dir ? model - 32'd1 : model + 32'd1;
      tick();
      checks++;
      if (bin32 !== model || gray32 !== (model ^ (model >> 1))) begin
        errors++;
        if (bad < 10)
          $display("FAIL random cycle %0d: bin=%h gray=%h, want %h %h", i, bin32, gray32, model, model ^ (model >> 1));
        bad++;
      end
    end
    load32 = 1'b0; en32 = 1'b0; dir32 = 1'b0;
    #1;
    checks++;
    if (err32 !== 1'b0) begin
      errors++;
      $display("FAIL random err_step: got %b, want 0", err32);
    end
  endtask

`ifdef GRAY_COUNTER_DOWN_EN
  task automatic test_down();
    rst32 = 1'b1; en32 = 1'b0; load32 = 1'b0; dir32 = 1'b0;
    tick();
    rst32 = 1'b0; dir32 = 1'b1;
    #1;
    checks++;
    if (tc32 !== 1'b1) begin
      errors++;
      $display("FAIL down tc at 0: got %b, want 1", tc32);
    end
    en32 = 1'b1;
    tick();
    en32 = 1'b0;
    checks++;
    if (bin32 !== 32'hFFFF_FFFF || gray32 !== 32'h8000_0000 || err32 !== 1'b0) begin
      errors++;
      $display("FAIL down wrap: bin=%h gray=%h err=%b, want ffffffff 80000000 0", bin32, gray32, err32);
    end
    dir32 = 1'b0;
    #1;
    checks++;
    if (tc32 !== 1'b1) begin
      errors++;
      $display("FAIL down tc at all ones: got %b, want 1", tc32);
    end
    tick();
    checks++;
    if (bin32 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL down hold: bin=%h, want ffffffff", bin32);
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_count();
    test_wrap();
    test_load_priority();
    test_mid_reset();
    test_random32();
`ifdef GRAY_COUNTER_DOWN_EN
    test_down();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
